feat_buf_pingpong: RTL and testbench
====================================

Name: feat_buf_pingpong

Overview:
- Parametrised, double-buffered feature buffer between layer engines (CONV/POOL) of the NN datapath.
- Producer fills one bank while the consumer reads the other. Banks swap through a commit/release handshake, so CONV and POOL of consecutive tiles overlap.
- Feature geometry is set at run time as log2 dimensions per layer, not hard-coded per state.
- Two read modes from the same bank: 3x3 windowed single-word reads with zero padding, and 2-wide x-pair reads for 2x2 pooling.

Parameters:
- DATSIZE, 22, data word width (signed fixed point).
- ADDR_W, 12, per-bank address width; each bank holds 2**ADDR_W words.
- DIM_W, 6, width of y/x/c coordinates.
- LOG_W, 3, width of the log2 dimension config fields.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- cfg_load  in  1  latch cfg_* (legal only when both banks EMPTY)
- cfg_hl, cfg_wl, cfg_cl  in  LOG_W each  log2 of height, width, channels; requires hl+wl+cl <= ADDR_W
- wr_ready  out  1  write bank is EMPTY or FILLING
- wr_en  in  1  write strobe
- wr_y, wr_x, wr_c  in  DIM_W each  write coordinates
- wr_data  in  DATSIZE  write data
- wr_commit  in  1  write bank is complete; mark it FULL
- rd_valid  out  1  read bank is FULL
- rd_en  in  1  read strobe
- rd_mode  in  1  0 = window, 1 = pair
- rd_y, rd_x, rd_c  in  DIM_W each  read coordinates (pooled coordinates in pair mode)
- rd_s  in  4  window shift 0..8, row-major 3x3, 4 = centre
- rd_updown  in  1  pair mode: 0 = row 2y, 1 = row 2y+1
- rd_release  in  1  consumer finished; mark read bank EMPTY
- rd_data  out  2*DATSIZE  window mode: {DATSIZE'0, word}; pair mode: {x=2p+1, x=2p}
- rd_data_vld  out  1  rd_data is valid this cycle
- ovf_err  out  1  sticky: write dropped or commit while not ready

Behaviour:
- Reset: both banks EMPTY, wr_bank=0, rd_bank=0, cfg fields 0, all outputs 0. Reset mid-operation discards all contents; no RAM clear is needed.
- Bank state per bank: EMPTY -> FILLING on the first accepted wr_en -> FULL on wr_commit -> EMPTY on rd_release.
- wr_commit on an EMPTY bank commits it with no data written (empty tile is allowed).
- On commit: wr_bank toggles next cycle. wr_ready is deasserted until the new wr_bank is EMPTY.
- rd_valid = (state[rd_bank] == FULL). On rd_release: rd_bank toggles next cycle.
- rd_release while rd_valid=0 is ignored. wr_commit while wr_ready=0 is ignored and sets ovf_err.
- Simultaneous commit and release on different banks: both take effect in the same cycle. A bank can therefore go FULL->EMPTY while the other goes FILLING->FULL.
- wr_en while wr_ready=0: no RAM write; sets ovf_err. ovf_err clears only on rst.
- Address: addr = (c << (hl+wl)) | (y << wl) | x. Coordinate bits above the cfg width are masked off.
- Storage layout: each bank is two RAMs (even x, odd x), each 2**(ADDR_W-1) deep, indexed by addr>>1.
- Window mode:
  - ey = rd_y + dy, ex = rd_x + dx, in signed DIM_W+1 bits, with (dy,dx) in {-1,0,1} decoded from rd_s. rd_s > 8 is treated as 4.
  - Out of range (ey<0, ey>=2**hl, ex<0, ex>=2**wl): no RAM enable; data returns 0.
  - ex parity selects the even or odd RAM; the select is registered alongside the address.
- Pair mode: y = 2*rd_y + rd_updown; both RAMs are read at index addr(y, 2*rd_x, rd_c)>>1. No padding in this mode.
- Latency: 1 cycle.
  - rd_data_vld = registered (rd_en & rd_valid).
  - rd_data = 0 when rd_data_vld=0 or the window read was out of range.
  - rd_en while rd_valid=0 yields rd_data_vld=0 on the next cycle.
- Read and write always target different banks, so there is no read-during-write hazard.
- cfg_load while any bank is not EMPTY is ignored.

Decomposition:
- Package feat_buf_pkg holds:
  - bank-state encoding: EMPTY=2'b00, FILLING=2'b01, FULL=2'b10;
  - read-mode constants;
  - shift decode: a function mapping rd_s to (dy,dx);
  - address compose function.
- Sub-module feat_bank: one bank, even/odd simple dual-port RAM pair with a 1-cycle read port. Inferred RAM; instantiated twice.

Test Plan:
- Fill and read: cfg hl=wl=2, cl=0. Write 16 words with data = y*4+x, commit. rd_valid=1 on the next cycle. Window read y=1, x=1, s=0 -> 0 after 1 cycle; s=8 -> 10.
- Padding: same config, window read y=0, x=3, s=2 -> rd_data=0 with rd_data_vld=1. Same at s=4 -> 3.
- Pair mode: same config, read y=1, x=1, updown=1 -> row 3, x=2,3 -> {15, 14}.
- Ping-pong: commit bank 0, fill bank 1 while reading bank 0. Commit bank 1 and release bank 0 in the same cycle -> wr_ready=1 with bank 0 EMPTY, rd_valid=1 on bank 1.
- Overflow: both banks FULL, wr_en=1 -> ovf_err=1 and no data change (re-read returns the old values). ovf_err holds until rst.
- Reset mid-read: rst during a FULL/FILLING pair -> next cycle rd_valid=0, wr_ready=1, ovf_err=0, rd_data=0.

Source files
------------

// File: rtl/feat_buf_pkg.sv
// Shared types and helpers for the ping-pong feature buffer: bank states,
// read modes, 3x3 window shift decode and feature address composition.
package feat_buf_pkg;

  typedef enum logic [1:0] {
    BANK_EMPTY   = 2'b00,
    BANK_FILLING = 2'b01,
    BANK_FULL    = 2'b10
  } bank_state_e;

  localparam logic RD_WINDOW = 1'b0;
  localparam logic RD_PAIR   = 1'b1;

  localparam logic [3:0] SHIFT_CENTRE = 4'd4;

  typedef struct packed {
    logic signed [1:0] dy;
    logic signed [1:0] dx;
  } shift_t;

  // Row-major 3x3 neighbourhood; codes above 8 alias the centre tap.
  function automatic shift_t decode_shift(input logic [3:0] s);
    shift_t     r;
    logic [3:0] k;
    k = (s > 4'd8) ? SHIFT_CENTRE : s;
    case (k)
      4'd0, 4'd1, 4'd2: r.dy = -2'sd1;
      4'd3, 4'd4, 4'd5: r.dy = 2'sd0;
      default:          r.dy = 2'sd1;
    endcase
    case (k)
      4'd0, 4'd3, 4'd6: r.dx = -2'sd1;
      4'd1, 4'd4, 4'd7: r.dx = 2'sd0;
      default:          r.dx = 2'sd1;
    endcase
    return r;
  endfunction

  // Channel-major, then row, then column; coordinates are masked to their field width.
  function automatic logic [31:0] compose_addr(input logic [31:0] y, input logic [31:0] x,
                                               input logic [31:0] c, input logic [7:0] hl,
                                               input logic [7:0] wl, input logic [7:0] cl);
    logic [31:0] ym, xm, cm;
    ym = y & ((32'd1 << hl) - 32'd1);
    xm = x & ((32'd1 << wl) - 32'd1);
    cm = c & ((32'd1 << cl) - 32'd1);
    return (cm << (hl + wl)) | (ym << wl) | xm;
  endfunction

endpackage

// File: rtl/feat_bank.sv
// One feature bank: even-x and odd-x simple dual-port RAMs sharing a read index,
// each with a registered (1-cycle) read port.
module feat_bank
  import feat_buf_pkg::*;
#(
  parameter int DATSIZE = 22,
  parameter int ADDR_W  = 12
) (
  input  logic               clk,
  input  logic               wr_en,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic [DATSIZE-1:0] wr_data,
  input  logic               rd_even,
  input  logic               rd_odd,
  input  logic [ADDR_W-2:0]  rd_idx,
  output logic [DATSIZE-1:0] q_even,
  output logic [DATSIZE-1:0] q_odd
);

  localparam int DEPTH = 2 ** (ADDR_W - 1);

  logic [DATSIZE-1:0] ram_even [DEPTH];
  logic [DATSIZE-1:0] ram_odd  [DEPTH];

  // NOTE: RAM arrays and their read registers take no reset; a reset would block
  // block-RAM inference, and every read is qualified by the registered valid instead.
  always_ff @(posedge clk) begin
    if (wr_en && !wr_addr[0]) ram_even[wr_addr[ADDR_W-1:1]] <= wr_data;
    if (rd_even)              q_even <= ram_even[rd_idx];
  end

  always_ff @(posedge clk) begin
    if (wr_en && wr_addr[0]) ram_odd[wr_addr[ADDR_W-1:1]] <= wr_data;
    if (rd_odd)              q_odd <= ram_odd[rd_idx];
  end

endmodule

// File: rtl/feat_buf_pingpong.sv
// Double-buffered feature buffer: the producer fills one bank while the consumer
// reads the other (3x3 padded window or 2-wide pooling pairs); banks swap on commit/release.
module feat_buf_pingpong
  import feat_buf_pkg::*;
#(
  parameter int DATSIZE = 22,
  parameter int ADDR_W  = 12,
  parameter int DIM_W   = 6,
  parameter int LOG_W   = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_load,
  input  logic [LOG_W-1:0]     cfg_hl,
  input  logic [LOG_W-1:0]     cfg_wl,
  input  logic [LOG_W-1:0]     cfg_cl,
  output logic                 wr_ready,
  input  logic                 wr_en,
  input  logic [DIM_W-1:0]     wr_y,
  input  logic [DIM_W-1:0]     wr_x,
  input  logic [DIM_W-1:0]     wr_c,
  input  logic [DATSIZE-1:0]   wr_data,
  input  logic                 wr_commit,
  output logic                 rd_valid,
  input  logic                 rd_en,
  input  logic                 rd_mode,
  input  logic [DIM_W-1:0]     rd_y,
  input  logic [DIM_W-1:0]     rd_x,
  input  logic [DIM_W-1:0]     rd_c,
  input  logic [3:0]           rd_s,
  input  logic                 rd_updown,
  input  logic                 rd_release,
  output logic [2*DATSIZE-1:0] rd_data,
  output logic                 rd_data_vld,
  output logic                 ovf_err
);

  bank_state_e      st [2];
  logic             wr_bank, rd_bank;
  logic [LOG_W-1:0] geo_hl, geo_wl, geo_cl;

  assign wr_ready = (st[wr_bank] == BANK_EMPTY) || (st[wr_bank] == BANK_FILLING);
  assign rd_valid = (st[rd_bank] == BANK_FULL);

  logic wr_ok, commit_ok, release_ok, rd_fire, banks_idle;
  assign wr_ok      = wr_en && wr_ready;
  assign commit_ok  = wr_commit && wr_ready;
  assign release_ok = rd_release && rd_valid;
  assign rd_fire    = rd_en && rd_valid;
  assign banks_idle = (st[0] == BANK_EMPTY) && (st[1] == BANK_EMPTY);

  logic [ADDR_W-1:0] wr_addr;
  assign wr_addr = ADDR_W'(compose_addr(32'(wr_y), 32'(wr_x), 32'(wr_c),
                                        8'(geo_hl), 8'(geo_wl), 8'(geo_cl)));

  // Window tap in DIM_W+1 bits; the MSB marks a negative coordinate.
  shift_t           sh;
  logic [DIM_W:0]   ey, ex;
  logic             win_oor;
  logic [ADDR_W-2:0] win_idx, pair_idx, rd_idx;

  assign sh      = decode_shift(rd_s);
  assign ey      = {1'b0, rd_y} + {{(DIM_W-1){sh.dy[1]}}, sh.dy};
  assign ex      = {1'b0, rd_x} + {{(DIM_W-1){sh.dx[1]}}, sh.dx};
  assign win_oor = ey[DIM_W] || ex[DIM_W] || ((ey >> geo_hl) != '0) || ((ex >> geo_wl) != '0);
  assign win_idx = (ADDR_W-1)'(compose_addr(32'(ey[DIM_W-1:0]), 32'(ex[DIM_W-1:0]), 32'(rd_c),
                                            8'(geo_hl), 8'(geo_wl), 8'(geo_cl)) >> 1);
  assign pair_idx = (ADDR_W-1)'(compose_addr(32'({rd_y, rd_updown}), 32'(rd_x) << 1, 32'(rd_c),
                                             8'(geo_hl), 8'(geo_wl), 8'(geo_cl)) >> 1);
  assign rd_idx   = (rd_mode == RD_PAIR) ? pair_idx : win_idx;

  logic en_even, en_odd;
  assign en_even = rd_fire && ((rd_mode == RD_PAIR) || (!win_oor && !ex[0]));
  assign en_odd  = rd_fire && ((rd_mode == RD_PAIR) || (!win_oor &&  ex[0]));

  logic [DATSIZE-1:0] q_even [2];
  logic [DATSIZE-1:0] q_odd  [2];

  for (genvar b = 0; b < 2; b++) begin : g_bank
    feat_bank #(.DATSIZE(DATSIZE), .ADDR_W(ADDR_W)) u_bank (
      .clk     (clk),
      .wr_en   (wr_ok && (wr_bank == 1'(b))),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_even (en_even && (rd_bank == 1'(b))),
      .rd_odd  (en_odd && (rd_bank == 1'(b))),
      .rd_idx  (rd_idx),
      .q_even  (q_even[b]),
      .q_odd   (q_odd[b])
    );
  end

  // NOTE: non-blocking updates to the same bank state are ordered so that a
  // commit in the same cycle as the first write overrides FILLING with FULL.
  always_ff @(posedge clk) begin
    if (rst) begin
      st[0]       <= BANK_EMPTY;
      st[1]       <= BANK_EMPTY;
      wr_bank     <= 1'b0;
      rd_bank     <= 1'b0;
      geo_hl      <= '0;
      geo_wl      <= '0;
      geo_cl      <= '0;
      ovf_err     <= 1'b0;
      rd_data_vld <= 1'b0;
    end else begin
      if (cfg_load && banks_idle) begin
        geo_hl <= cfg_hl;
        geo_wl <= cfg_wl;
        geo_cl <= cfg_cl;
      end
      if (wr_ok && st[wr_bank] == BANK_EMPTY) st[wr_bank] <= BANK_FILLING;
      if (commit_ok) begin
        st[wr_bank] <= BANK_FULL;
        wr_bank     <= ~wr_bank;
      end
      if (release_ok) begin
        st[rd_bank] <= BANK_EMPTY;
        rd_bank     <= ~rd_bank;
      end
      if ((wr_en || wr_commit) && !wr_ready) ovf_err <= 1'b1;
      rd_data_vld <= rd_fire;
    end
  end

  // Read-side steering travels with the RAM read; qualified by rd_data_vld.
  logic rd_mode_q, rd_pad_q, rd_odd_q, rd_bank_q;
  always_ff @(posedge clk) begin
    if (rd_fire) begin
      rd_mode_q <= rd_mode;
      rd_pad_q  <= win_oor;
      rd_odd_q  <= ex[0];
      rd_bank_q <= rd_bank;
    end
  end

  // NOTE: default first so every path assigns rd_data and no latch is inferred.
  always_comb begin
    rd_data = '0;
    if (rd_data_vld) begin
      if (rd_mode_q == RD_PAIR)
        rd_data = {q_odd[rd_bank_q], q_even[rd_bank_q]};
      else if (!rd_pad_q)
        rd_data = {{DATSIZE{1'b0}}, rd_odd_q ? q_odd[rd_bank_q] : q_even[rd_bank_q]};
    end
  end

endmodule

// File: tb/tb_feat_buf_pingpong.sv
// Randomised bench for feat_buf_pingpong: a word-addressed reference model of both
// banks is compared every cycle, plus directed scenarios with hand-computed values.
module tb_feat_buf_pingpong;

  localparam int DAT = 22;
  localparam int AW  = 12;
  localparam int DW  = 6;
  localparam int LW  = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic            cfg_load;
  logic [LW-1:0]   cfg_hl, cfg_wl, cfg_cl;
  logic            wr_ready;
  logic            wr_en;
  logic [DW-1:0]   wr_y, wr_x, wr_c;
  logic [DAT-1:0]  wr_data;
  logic            wr_commit;
  logic            rd_valid;
  logic            rd_en;
  logic            rd_mode;
  logic [DW-1:0]   rd_y, rd_x, rd_c;
  logic [3:0]      rd_s;
  logic            rd_updown;
  logic            rd_release;
  logic [2*DAT-1:0] rd_data;
  logic            rd_data_vld;
  logic            ovf_err;

  always #5 clk = ~clk;

  feat_buf_pingpong #(.DATSIZE(DAT), .ADDR_W(AW), .DIM_W(DW), .LOG_W(LW)) dut (
    .clk(clk), .rst(rst), .cfg_load(cfg_load), .cfg_hl(cfg_hl), .cfg_wl(cfg_wl),
    .cfg_cl(cfg_cl), .wr_ready(wr_ready), .wr_en(wr_en), .wr_y(wr_y), .wr_x(wr_x),
    .wr_c(wr_c), .wr_data(wr_data), .wr_commit(wr_commit), .rd_valid(rd_valid),
    .rd_en(rd_en), .rd_mode(rd_mode), .rd_y(rd_y), .rd_x(rd_x), .rd_c(rd_c),
    .rd_s(rd_s), .rd_updown(rd_updown), .rd_release(rd_release), .rd_data(rd_data),
    .rd_data_vld(rd_data_vld), .ovf_err(ovf_err)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int          m_mem [2][4096];
  bit          m_full [2];
  bit          m_busy [2];
  int          m_wr, m_rd;
  int          m_hl, m_wl, m_cl;
  bit          m_ovf;
  bit          exp_vld;
  logic [43:0] exp_data;
  bit          m_rv, m_wrdy;
  bit          chk_en = 1'b0;

  function automatic int maddr(int y, int x, int c);
    return (c % (1 << m_cl)) * (1 << (m_hl + m_wl)) + (y % (1 << m_hl)) * (1 << m_wl)
           + (x % (1 << m_wl));
  endfunction

  function automatic logic [43:0] model_read(int mode, int y, int x, int c, int s, int ud);
    int k, ey, ex, y0;
    if (mode == 1) begin
      y0 = 2 * y + ud;
      return {22'(m_mem[m_rd][maddr(y0, 2 * x + 1, c)]), 22'(m_mem[m_rd][maddr(y0, 2 * x, c)])};
    end
    k  = (s > 8) ? 4 : s;
    ey = y + k / 3 - 1;
    ex = x + k % 3 - 1;
    if (ey < 0 || ey >= (1 << m_hl) || ex < 0 || ex >= (1 << m_wl)) return 44'd0;
    return 44'(m_mem[m_rd][maddr(ey, ex, c)]);
  endfunction

  initial begin
    m_full = '{0, 0}; m_busy = '{0, 0};
    m_wr = 0; m_rd = 0; m_hl = 0; m_wl = 0; m_cl = 0; m_ovf = 0;
    exp_vld = 0; exp_data = '0;
  end

  always @(posedge clk) begin
    if (rst) begin
      // storage survives reset, only bookkeeping restarts
      m_full = '{0, 0}; m_busy = '{0, 0};
      m_wr = 0; m_rd = 0; m_hl = 0; m_wl = 0; m_cl = 0; m_ovf = 0;
      exp_vld = 0; exp_data = '0;
    end else begin
      m_rv     = m_full[m_rd];
      m_wrdy   = !m_full[m_wr];
      exp_vld  = rd_en && m_rv;
      exp_data = exp_vld ? model_read(int'(rd_mode), int'(rd_y), int'(rd_x), int'(rd_c),
                                      int'(rd_s), int'(rd_updown)) : 44'd0;
      if (cfg_load && !m_busy[0] && !m_busy[1]) begin
        m_hl = int'(cfg_hl); m_wl = int'(cfg_wl); m_cl = int'(cfg_cl);
      end
      if (wr_en) begin
        if (m_wrdy) begin
          m_mem[m_wr][maddr(int'(wr_y), int'(wr_x), int'(wr_c))] = int'(wr_data);
          m_busy[m_wr] = 1;
        end else m_ovf = 1;
      end
      if (wr_commit) begin
        if (m_wrdy) begin
          m_full[m_wr] = 1; m_busy[m_wr] = 1; m_wr = 1 - m_wr;
        end else m_ovf = 1;
      end
      if (rd_release && m_rv) begin
        m_full[m_rd] = 0; m_busy[m_rd] = 0; m_rd = 1 - m_rd;
      end
    end
  end

  // every-cycle comparison against the model
  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      check("wr_ready", 64'(wr_ready), 64'(!m_full[m_wr]));
      check("rd_valid", 64'(rd_valid), 64'(m_full[m_rd]));
      check("ovf_err", 64'(ovf_err), 64'(m_ovf));
      check("rd_data_vld", 64'(rd_data_vld), 64'(exp_vld));
      check("rd_data", 64'(rd_data), 64'(exp_data));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    cfg_load = 0; wr_en = 0; wr_commit = 0; rd_en = 0; rd_release = 0;
  endtask

  task automatic set_wr(int y, int x, int c, int d);
    wr_en = 1; wr_y = DW'(y); wr_x = DW'(x); wr_c = DW'(c); wr_data = DAT'(d);
  endtask

  task automatic set_rd(int mode, int y, int x, int c, int s, int ud);
    rd_en = 1; rd_mode = 1'(mode); rd_y = DW'(y); rd_x = DW'(x); rd_c = DW'(c);
    rd_s = 4'(s); rd_updown = 1'(ud);
  endtask

  task automatic read_chk(string name, int mode, int y, int x, int s, int ud, logic [63:0] exp);
    set_rd(mode, y, x, 0, s, ud);
    tick();
    idle();
    check({name, "_vld"}, 64'(rd_data_vld), 64'd1);
    check(name, 64'(rd_data), exp);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int hl, wl, cl, hh, ww, size, fill, commits;
    rst = 1; idle();
    cfg_hl = 0; cfg_wl = 0; cfg_cl = 0;
    wr_y = 0; wr_x = 0; wr_c = 0; wr_data = 0;
    rd_mode = 0; rd_y = 0; rd_x = 0; rd_c = 0; rd_s = 0; rd_updown = 0;
    tick();
    chk_en = 1;
    tick();
    rst = 0;
    tick();
    check("reset_wr_ready", 64'(wr_ready), 64'd1);
    check("reset_rd_valid", 64'(rd_valid), 64'd0);
    check("reset_ovf", 64'(ovf_err), 64'd0);
    check("reset_rd_data", 64'(rd_data), 64'd0);

    // 4x4x1 tile, data = y*4+x
    cfg_load = 1; cfg_hl = 2; cfg_wl = 2; cfg_cl = 0;
    tick(); idle();
    for (int i = 0; i < 16; i++) begin
      set_wr(i / 4, i % 4, 0, i);
      tick();
    end
    idle(); wr_commit = 1;
    tick(); idle();
    check("fill_rd_valid", 64'(rd_valid), 64'd1);
    check("fill_wr_ready", 64'(wr_ready), 64'd1);
    read_chk("win_s0", 0, 1, 1, 0, 0, 64'd0);
    read_chk("win_s8", 0, 1, 1, 8, 0, 64'd10);
    read_chk("pad_s2", 0, 0, 3, 2, 0, 64'd0);
    read_chk("pad_s4", 0, 0, 3, 4, 0, 64'd3);
    read_chk("pair_ud1", 1, 1, 1, 0, 1, (64'd15 << 22) | 64'd14);

    // ping-pong: fill bank 1 while reading bank 0
    for (int i = 0; i < 16; i++) begin
      set_wr(i / 4, i % 4, 0, 100 + i);
      set_rd(int'($urandom_range(0, 1)), int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
             0, int'($urandom_range(0, 15)), int'($urandom_range(0, 1)));
      tick();
    end
    idle(); wr_commit = 1; rd_release = 1;
    tick(); idle();
    check("swap_wr_ready", 64'(wr_ready), 64'd1);
    check("swap_rd_valid", 64'(rd_valid), 64'd1);
    read_chk("bank1_centre", 0, 1, 1, 4, 0, 64'd105);

    // overflow: commit empty bank 0 so both are FULL, then a dropped write
    wr_commit = 1;
    tick(); idle();
    check("both_full_wr_ready", 64'(wr_ready), 64'd0);
    set_wr(1, 1, 0, 999);
    tick(); idle();
    check("ovf_set", 64'(ovf_err), 64'd1);
    read_chk("ovf_reread", 0, 1, 1, 4, 0, 64'd105);
    read_chk("ovf_shift_oob", 0, 3, 3, 12, 0, 64'd115);
    rd_release = 1;
    tick(); idle();
    set_wr(0, 0, 0, 7);
    tick(); idle();
    check("ovf_sticky", 64'(ovf_err), 64'd1);

    // reset with bank 0 FULL, bank 1 FILLING, read in flight
    rst = 1; set_rd(0, 1, 1, 0, 4, 0);
    tick(); idle(); rst = 0;
    check("rst_rd_valid", 64'(rd_valid), 64'd0);
    check("rst_wr_ready", 64'(wr_ready), 64'd1);
    check("rst_ovf", 64'(ovf_err), 64'd0);
    check("rst_rd_data", 64'(rd_data), 64'd0);
    check("rst_rd_vld", 64'(rd_data_vld), 64'd0);

    // randomised producer/consumer episodes
    for (int ep = 0; ep < 6; ep++) begin
      hl = int'($urandom_range(1, 3)); wl = int'($urandom_range(1, 3)); cl = int'($urandom_range(0, 1));
      hh = 1 << hl; ww = 1 << wl; size = 1 << (hl + wl + cl);
      cfg_load = 1; cfg_hl = LW'(hl); cfg_wl = LW'(wl); cfg_cl = LW'(cl);
      tick(); idle();
      fill = 0; commits = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
        if (commits >= 4 && !m_busy[0] && !m_busy[1]) break;
        idle();
        if (!m_full[m_wr] && commits < 4) begin
          if (fill < size) begin
            if ($urandom_range(0, 3) != 0) begin
              set_wr((fill / ww) % hh, fill % ww, fill / (ww * hh), int'($urandom & 32'h3fffff));
              fill++;
            end
          end else if ($urandom_range(0, 2) == 0) begin
            wr_commit = 1; fill = 0; commits++;
          end
        end else if ($urandom_range(0, 31) == 0) begin
          set_wr(0, 0, 0, 1);
        end
        if ($urandom_range(0, 3) != 0) begin
          if ($urandom_range(0, 1) == 1)
            set_rd(1, int'($urandom_range(0, hh / 2 - 1)), int'($urandom_range(0, ww / 2 - 1)),
                   int'($urandom_range(0, (1 << cl) - 1)), 0, int'($urandom_range(0, 1)));
          else
            set_rd(0, int'($urandom_range(0, hh - 1)), int'($urandom_range(0, ww - 1)),
                   int'($urandom_range(0, (1 << cl) - 1)), int'($urandom_range(0, 15)), 0);
        end
        if ($urandom_range(0, 7) == 0) rd_release = 1;
        tick();
      end
      idle();
      tick();
      check("episode_drained", {62'd0, wr_ready, rd_valid}, 64'd2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
